// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 player decoder.
// Holds the prefix bytes, frame FSM states, control bit indices and the 20-entry key map.
package ps2_pkg;

    localparam logic [7:0] PREFIX_E0 = 8'hE0;
    localparam logic [7:0] PREFIX_F0 = 8'hF0;
    localparam logic [7:0] PREFIX_E1 = 8'hE1;

    localparam int NUM_CTRL_BITS = 5;
    localparam int BIT_UP        = 0;
    localparam int BIT_DOWN      = 1;
    localparam int BIT_LEFT      = 2;
    localparam int BIT_RIGHT     = 3;
    localparam int BIT_FIRE      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
        logic [1:0] player;
        logic [2:0] bit_idx;
    } key_map_t;

    // Table position is player*NUM_CTRL_BITS + bit; ext must match exactly.
    function automatic key_map_t key_map_entry(input int idx);
        key_map_t e;
        e.player  = 2'(idx / NUM_CTRL_BITS);
        e.bit_idx = 3'(idx % NUM_CTRL_BITS);
        case (idx)
            0:       {e.ext, e.code} = {1'b0, 8'h1D};
            1:       {e.ext, e.code} = {1'b0, 8'h1B};
            2:       {e.ext, e.code} = {1'b0, 8'h1C};
            3:       {e.ext, e.code} = {1'b0, 8'h23};
            4:       {e.ext, e.code} = {1'b0, 8'h2B};
            5:       {e.ext, e.code} = {1'b1, 8'h75};
            6:       {e.ext, e.code} = {1'b1, 8'h72};
            7:       {e.ext, e.code} = {1'b1, 8'h6B};
            8:       {e.ext, e.code} = {1'b1, 8'h74};
            9:       {e.ext, e.code} = {1'b0, 8'h5A};
            10:      {e.ext, e.code} = {1'b0, 8'h43};
            11:      {e.ext, e.code} = {1'b0, 8'h42};
            12:      {e.ext, e.code} = {1'b0, 8'h3B};
            13:      {e.ext, e.code} = {1'b0, 8'h4B};
            14:      {e.ext, e.code} = {1'b0, 8'h33};
            15:      {e.ext, e.code} = {1'b0, 8'h75};
            16:      {e.ext, e.code} = {1'b0, 8'h72};
            17:      {e.ext, e.code} = {1'b0, 8'h6B};
            18:      {e.ext, e.code} = {1'b0, 8'h74};
            19:      {e.ext, e.code} = {1'b0, 8'h70};
            default: {e.ext, e.code} = {1'b1, 8'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: synchronisers, clock glitch filter, falling-edge strobe,
// 11-bit frame FSM and inter-bit timeout. Emits one byte_valid or frame_err per frame.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [FILT_W-1:0]      filt_cnt_q;
    logic                   filt_q;
    logic                   clk_s;
    logic                   data_s;
    logic                   fe;

    frame_state_e state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_ok_q, par_ok_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Lines idle high, so the conditioning path resets high to avoid a false edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous
            // stage's old value, which is what turns this into a real shift chain.
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            if (clk_s == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_q     <= clk_s;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FILT_W'(1);
            end
        end
    end

    // Strobe on the cycle the filtered clock is about to fall.
    assign fe = filt_q && !clk_s && (filt_cnt_q == FILT_W'(FILTER_LEN - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and infers a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        to_cnt_d     = (state_q == ST_IDLE) ? '0 : to_cnt_q + TO_W'(1);
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;

        if (fe) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_o = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_ok_d = ^{shift_q, data_s};
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (data_s && par_ok_q) byte_valid_o = 1'b1;
                    else                    frame_err_o  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_d     = ST_IDLE;
            to_cnt_d    = '0;
            frame_err_o = 1'b1;
        end
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/ps2_player_decoder.sv
// PS/2 set-2 keyboard to multi-player control decoder: prefix tracking, key-map
// compare and the held-key ctrl register, all updated one cycle after the stop bit.
module ps2_player_decoder
    import ps2_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int CTRL_W      = 5,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                          board_clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [NUM_PLAYERS*CTRL_W-1:0] ctrl,
    output logic                          key_valid,
    output logic [7:0]                    scan_code,
    output logic                          scan_ext,
    output logic                          scan_break,
    output logic                          frame_err
);

    localparam int CW = NUM_PLAYERS * CTRL_W;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;
    logic       code_done;
    logic [CW-1:0] hit;

    logic [CW-1:0] ctrl_q, ctrl_d;
    logic          key_valid_q, key_valid_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          scan_ext_q, scan_ext_d;
    logic          scan_break_q, scan_break_d;
    logic          frame_err_q, frame_err_d;
    logic          ext_pend_q, ext_pend_d;
    logic          brk_pend_q, brk_pend_d;

    ps2_rx_frame #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_i        (board_clk),
        .reset_i      (reset),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .frame_err_o  (rx_err)
    );

    assign code_done = rx_valid && rx_byte != PREFIX_E0 && rx_byte != PREFIX_F0
                       && rx_byte != PREFIX_E1;

    // Only players below NUM_PLAYERS get compare logic, so higher players' keys never hit.
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        for (genvar b = 0; b < CTRL_W; b++) begin : g_bit
            localparam key_map_t ENTRY = key_map_entry(p * CTRL_W + b);
            localparam int       IDX   = int'(ENTRY.player) * CTRL_W + int'(ENTRY.bit_idx);
            assign hit[IDX] = code_done && (ext_pend_q == ENTRY.ext) && (rx_byte == ENTRY.code);
        end
    end

    always_comb begin
        ctrl_d       = brk_pend_q ? (ctrl_q & ~hit) : (ctrl_q | hit);
        key_valid_d  = 1'b0;
        scan_code_d  = scan_code_q;
        scan_ext_d   = scan_ext_q;
        scan_break_d = scan_break_q;
        frame_err_d  = rx_err;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;

        if (rx_err) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == PREFIX_E0) begin
                ext_pend_d = 1'b1;
            end else if (rx_byte == PREFIX_F0) begin
                brk_pend_d = 1'b1;
            end else if (rx_byte != PREFIX_E1) begin
                key_valid_d  = 1'b1;
                scan_code_d  = rx_byte;
                scan_ext_d   = ext_pend_q;
                scan_break_d = brk_pend_q;
                ext_pend_d   = 1'b0;
                brk_pend_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge board_clk) begin
        if (reset) begin
            ctrl_q       <= '0;
            key_valid_q  <= 1'b0;
            scan_code_q  <= '0;
            scan_ext_q   <= 1'b0;
            scan_break_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            key_valid_q  <= key_valid_d;
            scan_code_q  <= scan_code_d;
            scan_ext_q   <= scan_ext_d;
            scan_break_q <= scan_break_d;
            frame_err_q  <= frame_err_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
        end
    end

    assign ctrl       = ctrl_q;
    assign key_valid  = key_valid_q;
    assign scan_code  = scan_code_q;
    assign scan_ext   = scan_ext_q;
    assign scan_break = scan_break_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_player_decoder.sv
// Directed bench for ps2_player_decoder: table of single-byte frames plus
// hand-written timeout, glitch, typematic and mid-frame reset sequences.
module tb_ps2_player_decoder;
    import ps2_pkg::*;

    localparam int NP   = 4;
    localparam int CW   = 5;
    localparam int HALF = 30;
    localparam int TO   = 600;

    logic             board_clk = 1'b0;
    logic             reset;
    logic             ps2_clk;
    logic             ps2_data;
    logic [NP*CW-1:0] ctrl;
    logic             key_valid;
    logic [7:0]       scan_code;
    logic             scan_ext;
    logic             scan_break;
    logic             frame_err;

    int tests  = 0;
    int fails  = 0;
    int kv_cnt = 0;
    int er_cnt = 0;
    int kv0, er0;

    always #5 board_clk = ~board_clk;

    ps2_player_decoder #(
        .NUM_PLAYERS (NP),
        .CTRL_W      (CW),
        .SYNC_STAGES (2),
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TO)
    ) dut (
        .board_clk  (board_clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ctrl       (ctrl),
        .key_valid  (key_valid),
        .scan_code  (scan_code),
        .scan_ext   (scan_ext),
        .scan_break (scan_break),
        .frame_err  (frame_err)
    );

    always @(negedge board_clk) begin
        if (key_valid) kv_cnt++;
        if (frame_err) er_cnt++;
    end

    typedef struct {
        logic [7:0]  code;
        bit          bad_par;
        int          exp_kv;
        int          exp_err;
        logic [7:0]  exp_code;
        logic        exp_ext;
        logic        exp_brk;
        logic [19:0] exp_ctrl;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge board_clk);
    endtask

    // Drives the first n bits of an 11-bit frame; a glitch is inserted in bit glitch_at's high phase.
    task automatic send_bits(input logic [10:0] f, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            if (i == glitch_at) begin
                wait_cyc(5);
                ps2_clk = 1'b0;
                wait_cyc(4);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 9);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        wait_cyc(HALF);
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input int glitch_at);
        send_bits(frame_of(b, bad_par), 11, glitch_at);
    endtask

    task automatic check_key(input string name, input int dkv, input int der, input logic [7:0] code,
                             input logic ext, input logic brk, input logic [19:0] c);
        check({name, ".key_valid"}, 32'(kv_cnt - kv0), 32'(dkv));
        check({name, ".frame_err"}, 32'(er_cnt - er0), 32'(der));
        check({name, ".scan_code"}, 32'(scan_code), 32'(code));
        check({name, ".scan_ext"}, 32'(scan_ext), 32'(ext));
        check({name, ".scan_break"}, 32'(scan_break), 32'(brk));
        check({name, ".ctrl"}, 32'(ctrl), 32'(c));
    endtask

    task automatic mark();
        kv0 = kv_cnt;
        er0 = er_cnt;
    endtask

    initial begin
        vecs[0]  = '{8'h1D, 1'b0, 1, 0, 8'h1D, 1'b0, 1'b0, 20'h00001};
        vecs[1]  = '{8'hF0, 1'b0, 0, 0, 8'h1D, 1'b0, 1'b0, 20'h00001};
        vecs[2]  = '{8'h1D, 1'b0, 1, 0, 8'h1D, 1'b0, 1'b1, 20'h00000};
        vecs[3]  = '{8'hE0, 1'b0, 0, 0, 8'h1D, 1'b0, 1'b1, 20'h00000};
        vecs[4]  = '{8'h75, 1'b0, 1, 0, 8'h75, 1'b1, 1'b0, 20'h00020};
        vecs[5]  = '{8'h75, 1'b0, 1, 0, 8'h75, 1'b0, 1'b0, 20'h08020};
        vecs[6]  = '{8'hE0, 1'b0, 0, 0, 8'h75, 1'b0, 1'b0, 20'h08020};
        vecs[7]  = '{8'hF0, 1'b0, 0, 0, 8'h75, 1'b0, 1'b0, 20'h08020};
        vecs[8]  = '{8'h75, 1'b0, 1, 0, 8'h75, 1'b1, 1'b1, 20'h08000};
        vecs[9]  = '{8'h1C, 1'b1, 0, 1, 8'h75, 1'b1, 1'b1, 20'h08000};
        vecs[10] = '{8'h1C, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0, 20'h08004};
        vecs[11] = '{8'hE0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0, 20'h08004};
        vecs[12] = '{8'h72, 1'b1, 0, 1, 8'h1C, 1'b0, 1'b0, 20'h08004};
        vecs[13] = '{8'h72, 1'b0, 1, 0, 8'h72, 1'b0, 1'b0, 20'h18004};
        vecs[14] = '{8'h29, 1'b0, 1, 0, 8'h29, 1'b0, 1'b0, 20'h18004};
        vecs[15] = '{8'hE1, 1'b0, 0, 0, 8'h29, 1'b0, 1'b0, 20'h18004};
        vecs[16] = '{8'h14, 1'b0, 1, 0, 8'h14, 1'b0, 1'b0, 20'h18004};

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        @(negedge board_clk);
        check_key("reset", 0, 0, 8'h00, 1'b0, 1'b0, 20'h00000);
        reset = 1'b0;
        wait_cyc(20);

        for (int i = 0; i < 17; i++) begin
            mark();
            send_byte(vecs[i].code, vecs[i].bad_par, -1);
            check_key($sformatf("vec%0d", i), vecs[i].exp_kv, vecs[i].exp_err, vecs[i].exp_code,
                      vecs[i].exp_ext, vecs[i].exp_brk, vecs[i].exp_ctrl);
        end

        // Timeout after start + 4 data bits, then a clean frame.
        mark();
        send_bits(frame_of(8'h23, 1'b0), 5, -1);
        wait_cyc(TO + 40);
        check("timeout.frame_err", 32'(er_cnt - er0), 32'd1);
        check("timeout.key_valid", 32'(kv_cnt - kv0), 32'd0);
        check("timeout.state", 32'(dut.u_rx.state_q), 32'(ST_IDLE));
        mark();
        send_byte(8'h23, 1'b0, -1);
        check_key("after_timeout", 1, 0, 8'h23, 1'b0, 1'b0, 20'h1800C);

        // Short clock glitch mid-frame must not shift an extra bit.
        mark();
        send_byte(8'h2B, 1'b0, 4);
        check_key("glitch", 1, 0, 8'h2B, 1'b0, 1'b0, 20'h1801C);

        // Typematic repeats of held keys are no-ops on ctrl.
        mark();
        send_byte(8'h5A, 1'b0, -1);
        send_byte(8'h2B, 1'b0, -1);
        send_byte(8'h5A, 1'b0, -1);
        check_key("typematic", 3, 0, 8'h5A, 1'b0, 1'b0, 20'h1821C);

        // Reset in the middle of a frame clears everything on the next cycle.
        send_bits(frame_of(8'h1B, 1'b0), 4, -1);
        @(negedge board_clk);
        reset = 1'b1;
        @(negedge board_clk);
        mark();
        check_key("midreset", 0, 0, 8'h00, 1'b0, 1'b0, 20'h00000);
        check("midreset.key_valid_pin", 32'(key_valid), 32'd0);
        check("midreset.frame_err_pin", 32'(frame_err), 32'd0);
        reset = 1'b0;
        wait_cyc(20);
        mark();
        send_byte(8'h1D, 1'b0, -1);
        check_key("after_reset", 1, 0, 8'h1D, 1'b0, 1'b0, 20'h00001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_player_decoder.md
Name: ps2_player_decoder

Overview:
- Parametrised successor to the fixed two-player keyboard-to-game decoder.
- Receives PS/2 set-2 scan codes on the board clock and handles E0 (extended) and F0 (break) prefixes.
- Maintains a held-key control vector for up to 4 players, 5 bits each: up, down, left, right, fire.
- Adds parity/framing checks, an inter-bit timeout and a raw scan-code output.
- Feeds the colour generator's player control inputs.

Parameters:
- NUM_PLAYERS, 2, number of active players (1..4); sets the width of ctrl.
- CTRL_W, 5, control bits per player; fixed bit order {fire, right, left, down, up}.
- SYNC_STAGES, 2, synchroniser depth for ps2_clk and ps2_data (>=2).
- FILTER_LEN, 8, consecutive equal ps2_clk samples needed to accept a level change.
- TIMEOUT_CYC, 100000, board_clk cycles without a falling edge before a mid-frame abort.

Ports:
- board_clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  asynchronous PS/2 clock.
- ps2_data  in  1  asynchronous PS/2 data.
- ctrl  out  NUM_PLAYERS*CTRL_W  held-key vector; player p occupies bits [p*CTRL_W +: CTRL_W].
- key_valid  out  1  one-cycle pulse when a complete non-prefix code is accepted.
- scan_code  out  8  last completed code byte, held until the next key_valid.
- scan_ext  out  1  E0 prefix was present for scan_code.
- scan_break  out  1  F0 prefix was present for scan_code.
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Clock and reset: one clock, board_clk; reset is synchronous and active-high, named reset.
- Reset values: all outputs 0; frame FSM to IDLE; prefix flags, bit counter and timeout counter cleared.
  - Reset mid-frame discards the partial byte.
- Input conditioning:
  - Both inputs pass through SYNC_STAGES flops.
  - Filtered clock level changes only after FILTER_LEN identical consecutive samples.
  - The falling edge of the filtered clock produces a one-cycle strobe, fe.
- Frame FSM (advances only on fe; data sampled on the fe cycle):
  - IDLE: data=0 -> DATA with bit counter 0; data=1 -> stay in IDLE and pulse frame_err.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: check odd parity over 8 data bits plus the parity bit, store the result -> STOP.
  - STOP: if data=1 and parity ok, the byte is good, else pulse frame_err; -> IDLE either way.
- Timeout:
  - The counter runs in any state other than IDLE and resets on every fe.
  - Reaching TIMEOUT_CYC-1 -> IDLE, pulse frame_err, clear prefix flags.
- Prefix handling (on a good byte):
  - E0 sets ext_pend; F0 sets brk_pend; E1 is ignored. None of these pulse key_valid.
  - Any other byte completes a code:
    - scan_code=byte, scan_ext=ext_pend, scan_break=brk_pend.
    - Pulse key_valid, then clear both pending flags.
- Error handling: any frame_err clears ext_pend and brk_pend.
- Latency: key_valid, scan_* and ctrl all update on the cycle after the stop-bit fe (one register stage).
- Key map (extended flag, code) -> player/bit:
  - P0: W 1D up, S 1B down, A 1C left, D 23 right, F 2B fire (non-ext).
  - P1: E0 75 up, E0 72 down, E0 6B left, E0 74 right, 5A fire (non-ext Enter).
  - P2: I 43 up, K 42 down, J 3B left, L 4B right, H 33 fire.
  - P3: 75 up, 72 down, 6B left, 74 right, 70 fire (numpad, non-ext).
  - ext must match exactly; numpad 8 must not drive P1 up.
- ctrl update:
  - Make sets the mapped bit; break clears it.
  - Unmapped codes and players >= NUM_PLAYERS leave ctrl unchanged but still pulse key_valid.
  - Typematic repeats re-set an already-set bit, which is a no-op.
  - Simultaneous keys across players are independent.

Decomposition:
- Shared package ps2_pkg holds:
  - Prefix constants (E0, F0, E1).
  - Key-map table of 20 entries (ext, code, player, bit), indexed by player*5+bit.
  - Frame FSM state enum.
  - Control bit index constants.
- One sub-module, ps2_rx_frame: synchroniser, filter, edge detect, frame FSM and timeout. Outputs byte_valid, byte and frame_err.
- The top level holds the prefix logic, key-map compare and ctrl register.

Test Plan:
1. Reset, then frame 1D (parity 1) -> key_valid, scan_code=1D, ext=0, brk=0, ctrl[0]=1; then F0 1D -> ctrl[0]=0, scan_break=1.
2. E0 75 -> ctrl bit 5 (P1 up)=1, bit 15 unchanged; then 75 alone with NUM_PLAYERS=4 -> ctrl bit 15=1; E0 F0 75 clears bit 5 only.
3. Frame 1C with a wrong parity bit -> frame_err pulse, no key_valid, ctrl unchanged; next good 1C sets ctrl[2].
4. Send 4 bits of a frame, idle TIMEOUT_CYC cycles -> frame_err, FSM IDLE; next full frame 23 decodes correctly (ctrl[3]=1).
5. ps2_clk glitch shorter than FILTER_LEN cycles mid-frame -> no extra bit shifted; byte 2B decodes (ctrl[4]=1).
6. Press 2B and 5A and hold with typematic repeats, then reset asserted mid-frame -> ctrl=0 and all outputs 0 on the following cycle.
